// File: rtl/regfile_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of a shared register file.
// One operation is outstanding at a time: IDLE grants, ISSUE waits for ready, RESP returns read data.
module regfile_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              a_rready,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              b_rready,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en,
    input  logic              rf_write_rdy,
    output logic [ADDR_W-1:0] rf_read_address,
    output logic              rf_read_en,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic              rf_read_rdy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic       CID_A    = 1'b0;
    localparam logic       CID_B    = 1'b1;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              ptr_r;
    logic              we_r;
    logic              id_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;

    logic in_idle_s;
    logic in_issue_s;
    logic in_resp_s;
    logic grant_a_s;
    logic grant_b_s;
    logic wr_fire_s;
    logic rd_fire_s;
    logic resp_fire_s;

    // State decode and handshake qualifiers; everything is forced quiet while reset is held.
    always_comb begin
        in_idle_s   = RST_N && (state_r == ST_IDLE);
        in_issue_s  = RST_N && (state_r == ST_ISSUE);
        in_resp_s   = RST_N && (state_r == ST_RESP);
        grant_a_s   = in_idle_s && a_req && (!b_req || (ptr_r == CID_A));
        grant_b_s   = in_idle_s && b_req && (!a_req || (ptr_r == CID_B));
        wr_fire_s   = in_issue_s && we_r && rf_write_rdy;
        rd_fire_s   = in_issue_s && !we_r && rf_read_rdy;
        resp_fire_s = in_resp_s && ((id_r == CID_A) ? a_rready : b_rready);
    end

    // Next-state selection for the IDLE/ISSUE/RESP sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_a_s || grant_b_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (wr_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (rd_fire_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_RESP: begin
                if (resp_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state, round-robin pointer, request latch and read-response capture.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            ptr_r   <= CID_A;
            we_r    <= 1'b0;
            id_r    <= CID_A;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_a_s || grant_b_s) begin
                we_r    <= grant_b_s ? b_we    : a_we;
                addr_r  <= grant_b_s ? b_addr  : a_addr;
                wdata_r <= grant_b_s ? b_wdata : a_wdata;
                id_r    <= grant_b_s ? CID_B   : CID_A;
                // The client just served loses priority on the next tie.
                ptr_r   <= grant_b_s ? CID_A   : CID_B;
            end else begin
                we_r    <= we_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                id_r    <= id_r;
                ptr_r   <= ptr_r;
            end
            if (rd_fire_s) begin
                rdata_r <= rf_read_data;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign a_gnt            = grant_a_s;
    assign b_gnt            = grant_b_s;
    // Enables follow ready directly so a stalled op never pulses early.
    assign rf_write_en      = wr_fire_s;
    assign rf_read_en       = rd_fire_s;
    assign rf_write_address = (in_issue_s && we_r)  ? addr_r  : {ADDR_W{1'b0}};
    assign rf_write_data    = (in_issue_s && we_r)  ? wdata_r : {DATA_W{1'b0}};
    assign rf_read_address  = (in_issue_s && !we_r) ? addr_r  : {ADDR_W{1'b0}};
    assign a_rvalid         = in_resp_s && (id_r == CID_A);
    assign b_rvalid         = in_resp_s && (id_r == CID_B);
    assign a_rdata          = a_rvalid ? rdata_r : {DATA_W{1'b0}};
    assign b_rdata          = b_rvalid ? rdata_r : {DATA_W{1'b0}};

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: stimulus pushes expected grants/results from a
// transaction-level model; an independent monitor pops and checks against DUT activity.
module tb_regfile_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       a_req, a_we, a_wdata, a_gnt, a_rvalid, a_rdata, a_rready;
    logic [2:0] a_addr;
    logic       b_req, b_we, b_wdata, b_gnt, b_rvalid, b_rdata, b_rready;
    logic [2:0] b_addr;
    logic [2:0] rf_write_address, rf_read_address;
    logic       rf_write_data, rf_write_en, rf_write_rdy;
    logic       rf_read_en, rf_read_data, rf_read_rdy;

    always #5 CLK = ~CLK;

    regfile_arbiter #(.ADDR_W(3), .DATA_W(1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_rready(a_rready),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rready(b_rready),
        .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
        .rf_write_en(rf_write_en), .rf_write_rdy(rf_write_rdy),
        .rf_read_address(rf_read_address), .rf_read_en(rf_read_en),
        .rf_read_data(rf_read_data), .rf_read_rdy(rf_read_rdy)
    );

    // Register-file stand-in: storage the DUT writes into and reads from.
    logic [7:0] rf_mem = 8'h00;
    assign rf_read_data = rf_mem[rf_read_address];
    always @(posedge CLK) begin
        if (rf_write_en && rf_write_rdy) rf_mem[rf_write_address] <= rf_write_data;
    end

    typedef struct packed {
        logic       cid;
        logic       we;
        logic [2:0] addr;
        logic       wd;
        logic       rdexp;
    } op_t;

    op_t        exp_q[$];
    logic [7:0] mem_m = 8'h00;
    logic       pref_m = 1'b0;
    int tests = 0, fails = 0, done_cnt = 0, gnt_cnt = 0;
    int a_hold = 0, b_hold = 0, w_hold = 0, r_hold = 0;
    bit all_ready = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ops take effect in grant order; ties go to the favoured client, which then flips.
    task automatic push_op(input logic cid, input logic we, input logic [2:0] addr, input logic wd);
        op_t it;
        it.cid   = cid;
        it.we    = we;
        it.addr  = addr;
        it.wd    = wd;
        it.rdexp = we ? 1'b0 : mem_m[addr];
        if (we) mem_m[addr] = wd;
        exp_q.push_back(it);
        pref_m = ~cid;
    endtask

    // Monitor: walks each granted op through issue and response, checking every cycle.
    initial begin
        op_t cur;
        int  ph;
        cur = '0;
        ph  = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                chk("reset_outputs", {17'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
                    rf_write_en, rf_read_en, rf_write_data, rf_write_address, rf_read_address}, 32'd0);
                exp_q.delete();
                ph = 0;
            end else begin
                chk("single_gnt", a_gnt & b_gnt, 0);
                chk("one_enable", rf_write_en & rf_read_en, 0);
                if (!a_rvalid) chk("a_rdata_gated", a_rdata, 0);
                if (!b_rvalid) chk("b_rdata_gated", b_rdata, 0);
                case (ph)
                    0: begin
                        chk("gnt_when_req", a_gnt | b_gnt, a_req | b_req);
                        chk("idle_quiet", {rf_write_en, rf_read_en, a_rvalid, b_rvalid,
                            rf_write_address, rf_read_address, rf_write_data}, 0);
                        if (a_gnt | b_gnt) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_gnt", exp_q.size(), 1);
                            end else begin
                                cur = exp_q.pop_front();
                                chk("gnt_client", b_gnt, cur.cid);
                                gnt_cnt++;
                                ph = 1;
                            end
                        end
                    end
                    1: begin
                        chk("no_gnt_issue", a_gnt | b_gnt, 0);
                        chk("no_rvalid_issue", a_rvalid | b_rvalid, 0);
                        if (cur.we) begin
                            chk("wr_en", rf_write_en, rf_write_rdy);
                            chk("rd_en_on_write", rf_read_en, 0);
                            chk("wr_addr", rf_write_address, cur.addr);
                            chk("wr_data", rf_write_data, cur.wd);
                            if (rf_write_rdy) begin done_cnt++; ph = 0; end
                        end else begin
                            chk("rd_en", rf_read_en, rf_read_rdy);
                            chk("wr_en_on_read", rf_write_en, 0);
                            chk("rd_addr", rf_read_address, cur.addr);
                            if (rf_read_rdy) ph = 2;
                        end
                    end
                    default: begin
                        chk("no_gnt_resp", a_gnt | b_gnt, 0);
                        chk("no_en_resp", rf_write_en | rf_read_en, 0);
                        chk("rvalid_owner", cur.cid ? b_rvalid : a_rvalid, 1);
                        chk("rvalid_other", cur.cid ? a_rvalid : b_rvalid, 0);
                        chk("rdata", cur.cid ? b_rdata : a_rdata, cur.rdexp);
                        if (cur.cid ? b_rready : a_rready) begin done_cnt++; ph = 0; end
                    end
                endcase
            end
        end
    end

    task automatic drive_ready();
        rf_write_rdy = (w_hold > 0) ? 1'b0 : (all_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
        rf_read_rdy  = (r_hold > 0) ? 1'b0 : (all_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
        if (w_hold > 0) w_hold--;
        if (r_hold > 0) r_hold--;
        a_rready = (a_hold > 0) ? 1'b0 : (all_ready ? 1'b1 : 1'($urandom_range(0, 1)));
        b_rready = (b_hold > 0) ? 1'b0 : (all_ready ? 1'b1 : 1'($urandom_range(0, 1)));
    endtask

    // One clock: clients drop req after seeing gnt, response holds count down on rvalid.
    task automatic tick();
        logic ga, gb;
        @(negedge CLK);
        ga = a_gnt;
        gb = b_gnt;
        if (a_rvalid && !a_rready && a_hold > 0) a_hold--;
        if (b_rvalid && !b_rready && b_hold > 0) b_hold--;
        @(posedge CLK);
        #1;
        if (ga) a_req = 1'b0;
        if (gb) b_req = 1'b0;
        drive_ready();
    endtask

    task automatic run_round(input logic ra, input logic rb, input logic stag,
                             input logic aw, input logic [2:0] aa, input logic ad,
                             input logic bw, input logic [2:0] ba, input logic bd);
        int   start, n, k;
        logic first_b;
        start   = done_cnt;
        n       = (ra ? 1 : 0) + (rb ? 1 : 0);
        first_b = (ra && rb) ? (stag ? 1'b0 : pref_m) : rb;
        if (first_b) begin
            push_op(1'b1, bw, ba, bd);
            if (ra) push_op(1'b0, aw, aa, ad);
        end else begin
            if (ra) push_op(1'b0, aw, aa, ad);
            if (rb) push_op(1'b1, bw, ba, bd);
        end
        a_we = aw; a_addr = aa; a_wdata = ad;
        b_we = bw; b_addr = ba; b_wdata = bd;
        a_req = ra;
        b_req = rb && !stag;
        k = 0;
        while ((done_cnt - start) < n && k < 300) begin
            tick();
            k++;
            if (k == 1 && stag && rb) b_req = 1'b1;
        end
        chk("round_done", done_cnt - start, n);
    endtask

    initial begin
        int g0, k;
        logic ra, rb;
        RST_N = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 1'b0; a_rready = 1'b0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 1'b0; b_rready = 1'b0;
        rf_write_rdy = 1'b0; rf_read_rdy = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        repeat (3) tick();

        // Fairness from reset: A first, then strict alternation.
        repeat (4) run_round(1'b1, 1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b0,
                             1'b0, 3'($urandom_range(0, 7)), 1'b0);
        // Write then read back address 5.
        run_round(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0);
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0);
        // Write stalled by four cycles of low ready.
        w_hold = 4;
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1);
        // Response backpressure while B waits.
        run_round(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0);
        a_hold = 3;
        run_round(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd2, 1'b0);

        all_ready = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            run_round(ra, rb, ra && rb && ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) tick();
        end

        // Reset while a read is stuck in issue; the op must vanish.
        all_ready = 1'b1;
        r_hold = 1000;
        push_op(1'b0, 1'b0, 3'd1, 1'b0);
        a_we = 1'b0; a_addr = 3'd1; a_req = 1'b1;
        g0 = gnt_cnt;
        k = 0;
        while (gnt_cnt == g0 && k < 20) begin tick(); k++; end
        chk("midop_gnt", gnt_cnt - g0, 1);
        tick();
        RST_N = 1'b0;
        a_req = 1'b0;
        pref_m = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        r_hold = 0;
        rf_read_rdy = 1'b1;
        repeat (3) tick();
        run_round(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd6, 1'b0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-client arbiter and sequencer for the shared register-file `dut`. That block has 8 entries of 1 bit each, with write/read method ports and enable/ready handshakes.
- Accepts one request at a time from client A or client B, using fair round-robin.
- Issues the request to the register file once the matching ready is high.
- Returns read data to the originating client with a valid/ready handshake.
- Sits between the bus-side clients and the `dut` method ports, on the same `CLK` domain.

Parameters:
- ADDR_W, 3, register-file address width (entries = 2**ADDR_W).
- DATA_W, 1, register-file data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- a_req  in  1  client A request valid.
- a_we  in  1  client A op: 1 = write, 0 = read.
- a_addr  in  ADDR_W  client A address.
- a_wdata  in  DATA_W  client A write data.
- a_gnt  out  1  client A request accepted this cycle.
- a_rvalid  out  1  client A read response valid.
- a_rdata  out  DATA_W  client A read data.
- a_rready  in  1  client A accepts response.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_rready: identical to the A ports, for client B.
- rf_write_address  out  ADDR_W  to register-file write_address.
- rf_write_data  out  DATA_W  to register-file write_data.
- rf_write_en  out  1  to register-file write_en.
- rf_write_rdy  in  1  from register-file write_rdy.
- rf_read_address  out  ADDR_W  to register-file read_address.
- rf_read_en  out  1  to register-file read_en.
- rf_read_data  in  DATA_W  from register-file read_data; valid in the same cycle as read_en & read_rdy.
- rf_read_rdy  in  1  from register-file read_rdy.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - State goes to IDLE.
  - All outputs are 0: gnt, rvalid, rdata, rf_* enables/addresses/data.
  - Priority pointer favours A.
  - Any in-flight op is abandoned; no enable is asserted afterwards for it.
- One outstanding op at a time. State machine: IDLE, ISSUE, RESP.
- IDLE:
  - Arbitration is combinational over a_req/b_req.
  - If only one client requests, that client wins.
  - If both request, the client named by the pointer wins.
  - The winner's gnt is high for exactly this cycle. we, addr, wdata and a client id are latched at the edge.
  - The pointer flips to the other client after every grant.
  - Next state is ISSUE.
  - With no request, stay in IDLE with all outputs 0.
- ISSUE, latched write:
  - rf_write_address and rf_write_data are driven from the latch.
  - rf_write_en = rf_write_rdy, i.e. asserted only in the cycle where ready is high.
  - When en & rdy, go to IDLE.
- ISSUE, latched read:
  - rf_read_address is driven from the latch.
  - rf_read_en = rf_read_rdy.
  - When en & rdy, capture rf_read_data into the response register and go to RESP.
- ISSUE with ready low: hold all latched values; enable stays low. There is no timeout.
- RESP:
  - The owning client's rvalid is 1 and its rdata is the captured data.
  - The other client's rvalid is 0.
  - Stay in RESP, data stable, until that client's rready=1 at an edge; then go to IDLE.
- rdata is 0 whenever the corresponding rvalid is 0.
- Requests from either client in ISSUE or RESP are ignored (gnt=0). Clients hold req until they see gnt.
- Latency with ready always high:
  - Write: gnt in cycle 0, rf_write_en in cycle 1, next grant possible in cycle 2.
  - Read: gnt in cycle 0, rf_read_en in cycle 1, rvalid from cycle 2. With rready=1 in cycle 2, next grant is in cycle 3.
- Addresses use full ADDR_W with no wrap or check. All 2**ADDR_W entries are legal.
- rf_write_en and rf_read_en are never high in the same cycle.
- Reset asserted in ISSUE or RESP has priority over every transition.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles, no requests -> every output 0 and state IDLE; a_gnt and b_gnt both stay 0.
- Single write then read: A writes addr 5 data 1; A reads addr 5 with rready=1 -> rf_write_en one cycle with address 5 and data 1; later rf_read_en with address 5; a_rvalid=1 and a_rdata=1 two cycles after the read grant.
- Fairness: a_req and b_req held continuously, all reads, rready=1 -> grants alternate A, B, A, B, starting with A after reset; no client gets two grants in a row.
- Ready stall: B writes addr 2 while rf_write_rdy=0 for 4 cycles -> rf_write_en stays 0 and address/data stay stable; en pulses exactly once in the cycle rdy rises; no new grant until after that.
- Response backpressure: A reads addr 7, where 0 was stored; a_rready=0 for 3 cycles while b_req=1 -> a_rvalid held with a_rdata=0 and b_gnt=0 throughout; b_gnt=1 in the cycle after the a_rready handshake.
- Reset mid-op: grant a read; assert RST_N=0 during ISSUE with rf_read_rdy=0, then release and raise rdy -> no rf_read_en and no a_rvalid for the abandoned op; the next simultaneous A/B request grants A.
